play_select_ctrl: RTL and testbench

Upstream control stage for the playback output selector. It debounces three push-buttons (Bad Apple, Sakura, Stop) and produces the blanking enable and the one-hot track-select pair that drive the selector. It enforces a timed blanking interval on every track change and issues a restart pulse to the chosen player. The downstream selector routes channel 1 when {sakura,badapple}=10, routes channel 2 when {sakura,badapple}=01, and blanks on EN=1.

---
 rtl/play_pkg.sv | 20 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/play_select_ctrl.sv | 96 +++++++++
 tb/tb_play_select_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/play_pkg.sv
// play_pkg: shared FSM state, MODE status codes and track-target types for play_select_ctrl
//   state_t : IDLE / SWITCH / PLAY
//   MODE_*  : status codes driven on play_select_ctrl.MODE
//   tgt_t   : latched track target (TGT_BA is also the cleared value)
package play_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        PLAY   = 2'd2
    } state_t;

    typedef enum logic {
        TGT_BA = 1'b0,
        TGT_SK = 1'b1
    } tgt_t;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_SWITCH = 2'd1;
    localparam logic [1:0] MODE_PLAY   = 2'd2;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser plus counter debouncer for one push-button
//   CLK, RST : clock, asynchronous active-high reset
//   raw_i    : raw button level, asynchronous to CLK
//   level_o  : debounced level
//   press_o  : one-cycle pulse in the cycle the debounced level rises
module key_debounce #(
    parameter int DB_CYC = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    logic          s1_q, s2_q, level_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // The edge that completes DB_CYC consecutive mismatching cycles flips the level.
    assign flip  = (s2_q != level_q) && (cnt_q == CNT_LAST);
    assign cnt_d = (s2_q == level_q || flip) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_q ^ flip;
            press_q <= flip & ~level_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/play_select_ctrl.sv
// play_select_ctrl: debounced key control of blanking, one-hot track select and player restart
//   CLK, RST                 : clock, asynchronous active-high reset
//   KEY_BA, KEY_SK, KEY_STOP : raw active-high buttons, asynchronous to CLK
//   EN                       : blank request (1 = mute and black)
//   badapple, sakura         : one-hot track select, 00 while blanking
//   PLAY_RST                 : one-cycle restart pulse on the first PLAY cycle
//   MODE                     : 0 idle, 1 switching, 2 playing
module play_select_ctrl
    import play_pkg::*;
#(
    parameter int DB_CYC    = 1000000,
    parameter int BLANK_CYC = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_BA,
    input  logic       KEY_SK,
    input  logic       KEY_STOP,
    output logic       EN,
    output logic       badapple,
    output logic       sakura,
    output logic       PLAY_RST,
    output logic [1:0] MODE
);
    localparam int BW = $clog2(BLANK_CYC);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

    logic          ba_ev, sk_ev, stop_ev;
    logic          ba_lvl, sk_lvl, stop_lvl;
    logic          unused_lvl;
    state_t        state_q, state_d;
    tgt_t          tgt_q, tgt_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          en_q, ba_q, sk_q, prst_q;
    logic [1:0]    mode_q;

    key_debounce #(.DB_CYC(DB_CYC)) u_ba (
        .CLK(CLK), .RST(RST), .raw_i(KEY_BA), .level_o(ba_lvl), .press_o(ba_ev)
    );
    key_debounce #(.DB_CYC(DB_CYC)) u_sk (
        .CLK(CLK), .RST(RST), .raw_i(KEY_SK), .level_o(sk_lvl), .press_o(sk_ev)
    );
    key_debounce #(.DB_CYC(DB_CYC)) u_stop (
        .CLK(CLK), .RST(RST), .raw_i(KEY_STOP), .level_o(stop_lvl), .press_o(stop_ev)
    );

    assign unused_lvl = ^{ba_lvl, sk_lvl, stop_lvl};

    // STOP beats any track press; SK beats BA; any track press (re)starts blanking.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (stop_ev) begin
            state_d = IDLE;
            tgt_d   = TGT_BA;
            cnt_d   = '0;
        end else if (sk_ev || ba_ev) begin
            state_d = SWITCH;
            tgt_d   = sk_ev ? TGT_SK : TGT_BA;
            cnt_d   = '0;
        end else if (state_q == SWITCH) begin
            if (cnt_q == BLANK_LAST) state_d = PLAY;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are registered from the next state so select and EN change on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            tgt_q   <= TGT_BA;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            ba_q    <= 1'b0;
            sk_q    <= 1'b0;
            prst_q  <= 1'b0;
            mode_q  <= MODE_IDLE;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            en_q    <= state_d != PLAY;
            ba_q    <= state_d == PLAY && tgt_d == TGT_BA;
            sk_q    <= state_d == PLAY && tgt_d == TGT_SK;
            prst_q  <= state_d == PLAY && state_q == SWITCH;
            mode_q  <= state_d == PLAY ? MODE_PLAY : state_d == SWITCH ? MODE_SWITCH : MODE_IDLE;
        end
    end

    assign EN       = en_q;
    assign badapple = ba_q;
    assign sakura   = sk_q;
    assign PLAY_RST = prst_q;
    assign MODE     = mode_q;
endmodule

// File: tb/tb_play_select_ctrl.sv
// tb_play_select_ctrl: scoreboard bench; expected output changes are queued when keys are driven
module tb_play_select_ctrl;
    logic       clk = 1'b0, rst = 1'b0;
    logic       key_ba = 1'b0, key_sk = 1'b0, key_stop = 1'b0;
    logic       en, ba, sk, prst;
    logic [1:0] mode;
    logic [5:0] obs_v, prev_v;
    logic       mon_on = 1'b0, armed = 1'b0;
    int         cyc = 0, n_pass = 0, n_tot = 0;

    // Expected change of {MODE, EN, sakura, badapple, PLAY_RST} and the cycle it must appear.
    typedef struct {
        int         cyc;
        logic [5:0] v;
        string      tag;
    } exp_t;
    exp_t sb[$];
    exp_t cur_e;

    play_select_ctrl #(.DB_CYC(4), .BLANK_CYC(10)) dut (
        .CLK(clk), .RST(rst), .KEY_BA(key_ba), .KEY_SK(key_sk), .KEY_STOP(key_stop),
        .EN(en), .badapple(ba), .sakura(sk), .PLAY_RST(prst), .MODE(mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign obs_v = {mode, en, sk, ba, prst};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tot++;
        if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        else n_pass++;
    endtask

    task automatic push(input string tag, input int c, input logic [5:0] v);
        sb.push_back('{cyc: c, v: v, tag: tag});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (armed && !rst)
            assert (!(sk && ba) && (en || sk || ba))
            else begin
                n_tot++;
                $display("FAIL invariant: en=%b sel=%b%b", en, sk, ba);
            end
        if (mon_on && !rst && obs_v !== prev_v) begin
            if (sb.size() == 0) chk("unexpected_change", 32'(obs_v), 32'(prev_v));
            else begin
                cur_e = sb.pop_front();
                chk({cur_e.tag, "_cyc"}, cyc, cur_e.cyc);
                chk(cur_e.tag, 32'(obs_v), 32'(cur_e.v));
            end
        end
        prev_v = obs_v;
    end

    initial begin
        int n;
        cycles(2);
        #2 rst = 1'b1;
        armed = 1'b1;
        #1;
        chk("rst_en", 32'(en), 1);
        chk("rst_badapple", 32'(ba), 0);
        chk("rst_sakura", 32'(sk), 0);
        chk("rst_play_rst", 32'(prst), 0);
        chk("rst_mode", 32'(mode), 0);
        @(negedge clk);
        key_sk = 1'b1;
        cycles(8);
        key_sk = 1'b0;
        cycles(10);
        rst = 1'b0;
        mon_on = 1'b1;
        cycles(20);
        // short glitch, then a real SK press from IDLE
        key_sk = 1'b1;
        cycles(3);
        key_sk = 1'b0;
        cycles(4);
        n = cyc;
        key_sk = 1'b1;
        push("sk_switch", n + 7, 6'b01_1_00_0);
        push("sk_play", n + 17, 6'b10_0_10_1);
        push("sk_prst_end", n + 18, 6'b10_0_10_0);
        cycles(8);
        key_sk = 1'b0;
        cycles(22);
        // retarget PLAY(SK) to BA
        n = cyc;
        key_ba = 1'b1;
        push("ba_switch", n + 7, 6'b01_1_00_0);
        push("ba_play", n + 17, 6'b10_0_01_1);
        push("ba_prst_end", n + 18, 6'b10_0_01_0);
        cycles(8);
        key_ba = 1'b0;
        cycles(22);
        // SK press, then BA press landing in cycle 5 of SWITCH restarts blanking
        n = cyc;
        key_sk = 1'b1;
        push("re_switch", n + 7, 6'b01_1_00_0);
        push("re_play", n + 22, 6'b10_0_01_1);
        push("re_prst_end", n + 23, 6'b10_0_01_0);
        cycles(5);
        key_ba = 1'b1;
        cycles(3);
        key_sk = 1'b0;
        cycles(5);
        key_ba = 1'b0;
        cycles(25);
        // STOP and SK in the same cycle during PLAY
        n = cyc;
        key_stop = 1'b1;
        key_sk = 1'b1;
        push("stop_idle", n + 7, 6'b00_1_00_0);
        cycles(8);
        key_stop = 1'b0;
        key_sk = 1'b0;
        cycles(20);
        // SK and BA together from IDLE
        n = cyc;
        key_sk = 1'b1;
        key_ba = 1'b1;
        push("both_switch", n + 7, 6'b01_1_00_0);
        push("both_play", n + 17, 6'b10_0_10_1);
        push("both_prst_end", n + 18, 6'b10_0_10_0);
        cycles(8);
        key_sk = 1'b0;
        key_ba = 1'b0;
        cycles(22);
        // BA held for 100 cycles yields a single event
        n = cyc;
        key_ba = 1'b1;
        push("held_switch", n + 7, 6'b01_1_00_0);
        push("held_play", n + 17, 6'b10_0_01_1);
        push("held_prst_end", n + 18, 6'b10_0_01_0);
        cycles(100);
        key_ba = 1'b0;
        cycles(20);
        // reset mid-play takes effect without a clock edge
        mon_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midplay_rst_en", 32'(en), 1);
        chk("midplay_rst_badapple", 32'(ba), 0);
        chk("midplay_rst_sakura", 32'(sk), 0);
        chk("midplay_rst_mode", 32'(mode), 0);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
